isram_arbiter: RTL and testbench

ISRAM_ARBITER -- requirements
Module: isram_arbiter

---
 rtl/isram_arbiter.sv | 150 +++++++++++++++
 tb/tb_isram_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/isram_arbiter.sv
// Arbitrates one synchronous instruction SRAM between the fetch port and the load/store port.
// Load/store wins by default; a burst limit guarantees fetch a slot after LS_BURST back-to-back grants.
module isram_arbiter #(
    parameter int unsigned LS_BURST = 4
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        fe_req,
    input  logic [31:3] fe_adr,
    output logic        fe_gnt,
    output logic        fe_rvalid,
    output logic [63:0] fe_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:3] ls_adr,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [63:0] ls_rdata,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [31:3] sram_adr,
    output logic [63:0] sram_wdata,
    output logic [7:0]  sram_wmask,
    input  logic [63:0] sram_rdata,
    output logic        ls_busy,
    output logic        ls_busy_ff,
    output logic        fet_stall
);

    localparam logic [2:0] BURST_C = 3'(LS_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FE   = 2'd1,
        S_LS   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  ls_cnt_r;
    logic [2:0]  ls_cnt_nxt_s;
    logic        ls_we_r;
    logic [63:0] hold_r;
    logic        ls_busy_r;

    // Grant decision: load/store priority unless fetch has waited a full burst
    always_comb begin
        ls_gnt    = ls_req & ~(fe_req & (ls_cnt_r == BURST_C));
        fe_gnt    = fe_req & ~ls_gnt;
        fet_stall = fe_req & ~fe_gnt;
    end

    // Starvation counter: counts ls grants only while fetch is waiting
    always_comb begin
        ls_cnt_nxt_s = ls_cnt_r;
        if (!fe_req || fe_gnt) begin
            ls_cnt_nxt_s = 3'd0;
        end else if (ls_gnt && (ls_cnt_r < BURST_C)) begin
            ls_cnt_nxt_s = ls_cnt_r + 3'd1;
        end else begin
            ls_cnt_nxt_s = ls_cnt_r;
        end
    end

    // SRAM command mux; fetch never writes
    always_comb begin
        sram_cs    = fe_gnt | ls_gnt;
        sram_we    = 1'b0;
        sram_adr   = fe_adr;
        sram_wdata = 64'd0;
        sram_wmask = 8'd0;
        if (ls_gnt) begin
            sram_we    = ls_we;
            sram_adr   = ls_adr;
            sram_wdata = ls_wdata;
            sram_wmask = ls_wmask;
        end else begin
            sram_we    = 1'b0;
            sram_adr   = fe_adr;
            sram_wdata = 64'd0;
            sram_wmask = 8'd0;
        end
    end

    // Next owner of the SRAM read-data cycle
    always_comb begin
        state_nxt_s = S_IDLE;
        if (ls_gnt) begin
            state_nxt_s = S_LS;
        end else if (fe_gnt) begin
            state_nxt_s = S_FE;
        end else begin
            state_nxt_s = S_IDLE;
        end
    end

    // Response-side decode of the owner captured last cycle
    always_comb begin
        fe_rvalid = 1'b0;
        ls_busy   = 1'b0;
        case (state_r)
            S_FE:    fe_rvalid = 1'b1;
            S_LS:    ls_busy   = 1'b1;
            S_IDLE:  fe_rvalid = 1'b0;
            default: fe_rvalid = 1'b0;
        endcase
        ls_rvalid  = ls_busy & ~ls_we_r;
        ls_busy_ff = ls_busy_r;
    end

    // Read data steering; fetch keeps seeing its last instruction while load/store owns the SRAM
    always_comb begin
        ls_rdata = 64'd0;
        fe_rdata = hold_r;
        if (ls_rvalid) begin
            ls_rdata = sram_rdata;
        end else begin
            ls_rdata = 64'd0;
        end
        if (fe_rvalid) begin
            fe_rdata = sram_rdata;
        end else begin
            fe_rdata = hold_r;
        end
    end

    // State registers; reset discards any in-flight response
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_r   <= S_IDLE;
            ls_cnt_r  <= 3'd0;
            ls_we_r   <= 1'b0;
            hold_r    <= 64'd0;
            ls_busy_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ls_cnt_r  <= ls_cnt_nxt_s;
            ls_busy_r <= ls_busy;
            if (ls_gnt) begin
                ls_we_r <= ls_we;
            end
            if (fe_rvalid) begin
                hold_r <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_isram_arbiter.sv
// Randomized bench for isram_arbiter against a transaction-level model of grants and responses.
module tb_isram_arbiter;

    localparam int LS_BURST = 4;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        fe_req, ls_req, ls_we;
    logic [31:3] fe_adr, ls_adr;
    logic [63:0] ls_wdata, sram_rdata;
    logic [7:0]  ls_wmask;
    logic        fe_gnt, fe_rvalid, ls_gnt, ls_rvalid;
    logic [63:0] fe_rdata, ls_rdata, sram_wdata;
    logic        sram_cs, sram_we, ls_busy, ls_busy_ff, fet_stall;
    logic [31:3] sram_adr;
    logic [7:0]  sram_wmask;

    int errors = 0;
    int checks = 0;

    // Model: waiting-fetch burst count, owner of next response (0 none, 1 fetch, 2 ls)
    int          m_cnt;
    int          m_pend;
    logic        m_pend_we;
    logic        m_prev_busy;
    logic [63:0] m_hold;

    isram_arbiter #(.LS_BURST(LS_BURST)) dut (
        .clk(clk), .cpurst(cpurst),
        .fe_req(fe_req), .fe_adr(fe_adr), .fe_gnt(fe_gnt),
        .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_adr(ls_adr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr), .sram_wdata(sram_wdata),
        .sram_wmask(sram_wmask), .sram_rdata(sram_rdata),
        .ls_busy(ls_busy), .ls_busy_ff(ls_busy_ff), .fet_stall(fet_stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt       = 0;
        m_pend      = 0;
        m_pend_we   = 1'b0;
        m_prev_busy = 1'b0;
        m_hold      = 64'd0;
    endtask

    task automatic drive(input logic fr, input logic lr, input logic we, input logic [63:0] rd);
        fe_req     = fr;
        ls_req     = lr;
        ls_we      = we;
        sram_rdata = rd;
    endtask

    // Compare every output against the model, advance the model, move to the next negedge
    task automatic check_cycle();
        logic exp_ls, exp_fe, exp_lrv;
        exp_ls  = ls_req && !(fe_req && m_cnt == LS_BURST);
        exp_fe  = fe_req && !exp_ls;
        exp_lrv = (m_pend == 2) && !m_pend_we;
        check_eq("ls_gnt", ls_gnt, exp_ls);
        check_eq("fe_gnt", fe_gnt, exp_fe);
        check_eq("sram_cs", sram_cs, exp_ls || exp_fe);
        check_eq("sram_we", sram_we, exp_ls ? ls_we : 1'b0);
        check_eq("sram_adr", sram_adr, exp_ls ? ls_adr : fe_adr);
        check_eq("sram_wdata", sram_wdata, exp_ls ? ls_wdata : 64'd0);
        check_eq("sram_wmask", sram_wmask, exp_ls ? ls_wmask : 8'd0);
        check_eq("fet_stall", fet_stall, fe_req && !exp_fe);
        check_eq("fe_rvalid", fe_rvalid, m_pend == 1);
        check_eq("ls_rvalid", ls_rvalid, exp_lrv);
        check_eq("ls_rdata", ls_rdata, exp_lrv ? sram_rdata : 64'd0);
        check_eq("fe_rdata", fe_rdata, (m_pend == 1) ? sram_rdata : m_hold);
        check_eq("ls_busy", ls_busy, m_pend == 2);
        check_eq("ls_busy_ff", ls_busy_ff, m_prev_busy);
        if (m_pend == 1) m_hold = sram_rdata;
        m_prev_busy = (m_pend == 2);
        if (!fe_req || exp_fe) m_cnt = 0;
        else if (exp_ls && m_cnt < LS_BURST) m_cnt++;
        m_pend    = exp_ls ? 2 : (exp_fe ? 1 : 0);
        if (exp_ls) m_pend_we = ls_we;
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        check_cycle();
    endtask

    initial begin
        model_reset();
        cpurst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'hFFFF_0000_FFFF_0000);
        fe_adr = 29'h200; ls_adr = 29'h400; ls_wdata = 64'd0; ls_wmask = 8'd0;
        #1;
        check_eq("rst_fe_rvalid", fe_rvalid, 1'b0);
        check_eq("rst_ls_busy", ls_busy, 1'b0);
        check_eq("rst_ls_busy_ff", ls_busy_ff, 1'b0);
        check_eq("rst_fe_rdata", fe_rdata, 64'd0);
        check_eq("rst_fe_gnt_follows", fe_gnt, 1'b1);
        @(negedge clk);
        @(negedge clk);
        cpurst = 1'b0;

        // Fetch-only stream returns data one cycle after grant
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'hA5A5_0000_1234_5678);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 64'hA5A5_0000_1234_5678);
        #1;
        check_eq("dir_fe_rdata", fe_rdata, 64'hA5A5_0000_1234_5678);
        check_cycle();

        // Contention: LS,LS,LS,LS,FE repeating
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 64'h0);
            #1;
            check_eq("burst_pat", ls_gnt, (i % 5) != 4);
            check_cycle();
        end

        // Fetch 0x1111..., then two ls reads returning 0x2222...
        drive(1'b1, 1'b0, 1'b0, 64'h0);                       step();
        drive(1'b0, 1'b1, 1'b0, 64'h1111_1111_1111_1111);     step();
        drive(1'b0, 1'b1, 1'b0, 64'h2222_2222_2222_2222);
        #1;
        check_eq("dir_ls_rdata", ls_rdata, 64'h2222_2222_2222_2222);
        check_eq("dir_fe_hold", fe_rdata, 64'h1111_1111_1111_1111);
        check_cycle();
        drive(1'b0, 1'b0, 1'b0, 64'h2222_2222_2222_2222);     step();

        // Write produces no rvalid but marks ls_busy
        ls_wmask = 8'h0F; ls_wdata = 64'h0000_0000_DEAD_BEEF;
        drive(1'b0, 1'b1, 1'b1, 64'h0);
        #1;
        check_eq("dir_wr_we", sram_we, 1'b1);
        check_eq("dir_wr_mask", sram_wmask, 8'h0F);
        check_cycle();
        drive(1'b0, 1'b0, 1'b0, 64'h3333);
        #1;
        check_eq("dir_wr_norvalid", ls_rvalid, 1'b0);
        check_eq("dir_wr_busy", ls_busy, 1'b1);
        check_cycle();

        // Async reset right after a fetch grant kills the pending response
        drive(1'b1, 1'b0, 1'b0, 64'h0);                        step();
        drive(1'b0, 1'b0, 1'b0, 64'h4444_5555_6666_7777);
        #1;
        check_eq("pre_rst_fe_rvalid", fe_rvalid, 1'b1);
        cpurst = 1'b1;
        #1;
        check_eq("async_rst_fe_rvalid", fe_rvalid, 1'b0);
        check_eq("async_rst_fe_rdata", fe_rdata, 64'd0);
        check_eq("async_rst_ls_busy_ff", ls_busy_ff, 1'b0);
        cpurst = 1'b0;
        model_reset();
        @(negedge clk);
        step();

        // Randomized traffic with fetch biased high so the burst guard triggers often
        for (int i = 0; i < 3000; i++) begin
            fe_req     = ($urandom_range(0, 3) != 0);
            ls_req     = ($urandom_range(0, 4) < 3);
            ls_we      = $urandom_range(0, 1);
            fe_adr     = 29'($urandom);
            ls_adr     = 29'($urandom);
            ls_wdata   = {$urandom, $urandom};
            ls_wmask   = 8'($urandom);
            sram_rdata = {$urandom, $urandom};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
